// File: rtl/ucounter_pkg.sv
// ucounter_pkg: shared types, 7-segment lookup and binary-to-BCD helper
// for the ucounter_sync counter and its button debouncer.
package ucounter_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // Returns {tens, units}; input is at most 63, so tens never exceeds 6.
    function automatic logic [7:0] bin_to_bcd(input logic [5:0] bin);
        logic [5:0] tens;
        logic [5:0] units;
        tens  = bin / 6'd10;
        units = bin % 6'd10;
        return {4'(tens), 4'(units)};
    endfunction

endpackage

// File: rtl/ucounter_sync_if.sv
// ucounter_sync_if: button input and counter/display outputs of ucounter_sync.
// master = board/test side, slave = counter.
interface ucounter_sync_if #(
    parameter int N = 6
);
    logic         btn_increment;
    logic [N-1:0] count;
    logic         tick;
    logic [6:0]   segA;
    logic [6:0]   segB;

    modport master (
        output btn_increment,
        input  count,
        input  tick,
        input  segA,
        input  segB
    );

    modport slave (
        input  btn_increment,
        output count,
        output tick,
        output segA,
        output segB
    );
endinterface

// File: rtl/ucounter_sync_btn_debouncer.sv
// btn_debouncer: two-flop synchronizer plus debounce FSM for an active-low
// push button; emits a single-cycle press_pulse_o per accepted press.
//
// state        | meaning
// -------------+------------------------------------------------------
// IDLE         | button released and stable, waiting for a low level
// PRESS_WAIT   | button low, counting stable cycles before accepting
// HELD         | press accepted, waiting for a high level
// RELEASE_WAIT | button high, counting stable cycles before re-arming
module btn_debouncer
    import ucounter_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_b_i,
    input  logic btn_n_i,
    output logic press_pulse_o
);

    localparam int            CW   = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] TERM = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    deb_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;
    logic [CW-1:0] cnt_sat_inc;
    logic          term_hit;

    // Saturating increment so a very long stable level can never wrap the counter.
    assign cnt_sat_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign term_hit    = (cnt_sat_inc >= TERM);

    // Bring the asynchronous button into the clk domain; idle level is high.
    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM; press pulse is raised on the edge the press counter hits terminal.
    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!sync2_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (sync2_q) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_sat_inc;
                        if (term_hit) begin
                            state_q <= HELD;
                            press_q <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (sync2_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync2_q) begin
                        state_q <= HELD;
                    end else begin
                        cnt_q <= cnt_sat_inc;
                        if (term_hit) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press_pulse_o = press_q;

endmodule

// File: rtl/ucounter_sync.sv
// ucounter_sync: N-bit up counter advanced by a debounced active-low button,
// shown in decimal on two active-low 7-segment displays (segA units, segB tens).
// Build option: define UCOUNTER_SATURATE_EN to hold the count at 2^N-1
// instead of wrapping to 0; no tick is issued for a press at max.
module ucounter_sync
    import ucounter_pkg::*;
#(
    parameter int N          = 6,
    parameter int DEB_CYCLES = 500000
) (
    input  logic          clk,
    input  logic          btn_reset,
    ucounter_sync_if.slave bus
);

    localparam logic [N-1:0] COUNT_MAX = '1;

    logic         press_pulse;
    logic [N-1:0] count_q;
    logic         tick_q;
    logic [6:0]   seg_a_q;
    logic [6:0]   seg_b_q;
    logic [5:0]   count_ext;
    logic [7:0]   bcd;

    btn_debouncer #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debouncer (
        .clk_i         (clk),
        .rst_b_i       (btn_reset),
        .btn_n_i       (bus.btn_increment),
        .press_pulse_o (press_pulse)
    );

    // Count register; tick is high in the cycle following the edge that advanced count.
    always_ff @(posedge clk) begin
        if (!btn_reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (press_pulse) begin
`ifdef UCOUNTER_SATURATE_EN
                if (count_q != COUNT_MAX) begin
                    count_q <= count_q + 1'b1;
                    tick_q  <= 1'b1;
                end
`else
                count_q <= count_q + 1'b1;
                tick_q  <= 1'b1;
`endif
            end
        end
    end

    assign count_ext = 6'(count_q);
    assign bcd       = bin_to_bcd(count_ext);

    // Registered display decode, one cycle behind count; tens shows "0" rather than blank.
    always_ff @(posedge clk) begin
        if (!btn_reset) begin
            seg_a_q <= SEG_ZERO;
            seg_b_q <= SEG_ZERO;
        end else begin
            seg_a_q <= SEG_LUT[bcd[3:0]];
            seg_b_q <= SEG_LUT[bcd[7:4]];
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.segA  = seg_a_q;
    assign bus.segB  = seg_b_q;

endmodule

// File: doc/ucounter_sync.md
Name: ucounter_sync

Overview:
- Synchronous N-bit up counter, the counterpart of the board's decrementing counter.
- Driven by a noisy active-low push button (btn_increment); button is synchronized, debounced and edge-qualified, one increment per physical press.
- Value shown in decimal on two active-low 7-segment displays (segA = units, segB = tens).
- Sits between board buttons and the HEX displays in the Lab 2 top level.

Parameters:
- N, 6, counter width; legal range 1..6 so the maximum value 2^N-1 fits in two decimal digits.
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a press or release (10 ms at 50 MHz); benches override with 4.

Ports:
- clk, input, 1, system clock.
- btn_reset, input, 1, synchronous active-low reset.
- btn_increment, input, 1, raw active-low push button, asynchronous to clk.
- count, output, N, current counter value.
- tick, output, 1, one-cycle pulse in the cycle in which count increments.
- segA, output, 7, units digit; active-low; bit order {g,f,e,d,c,b,a}.
- segB, output, 7, tens digit; same encoding as segA.

Behaviour:
- Reset
  - Sampled at the rising clk edge; btn_reset=0 dominates all other activity.
  - Reset values: count=0, tick=0, segA=segB=7'b1000000 ("0"), synchronizer flops=1, debounce counter=0, FSM=IDLE.
- Synchronizer
  - Two flops on btn_increment; sync_n is the second flop's output.
- Debounce FSM (states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT)
  - IDLE: sync_n=0 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT:
    - sync_n=1 -> IDLE (glitch).
    - Otherwise counter++; when the counter reaches DEB_CYCLES-1 -> HELD and assert press_pulse for one cycle.
  - HELD: sync_n=1 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT:
    - sync_n=0 -> HELD (bounce).
    - Counter reaching DEB_CYCLES-1 -> IDLE.
  - Counter width is $clog2(DEB_CYCLES)+1; it saturates and never wraps.
- Count update
  - On press_pulse, count <= count+1 at the same edge, and tick=1 for that single cycle.
  - Latency: count changes at edge k+2+DEB_CYCLES, where edge k is the first edge to sample btn_increment=0, provided the input stays low throughout.
  - Holding the button gives exactly one increment.
  - A press shorter than DEB_CYCLES synchronized cycles gives no increment.
- Wrap: count=2^N-1 plus a press -> 0 (N=6: 63 -> 0); tick still pulses.
- Display
  - count is converted to BCD; units drive segA, tens drive segB.
  - Displays are registered: they update one cycle after count.
  - Tens digit shows "0" (not blank) for values below 10.
- Reset mid-operation
  - Any state returns to IDLE and count returns to 0.
  - A button still held low when reset releases is treated as a new press after the full debounce period.
- Simultaneous reset and press_pulse: reset wins and count=0.

Optional Feature:
- Macro: UCOUNTER_SATURATE_EN.
- Defined: count holds at 2^N-1 on further presses, and tick is not asserted when count is already at max.
- Undefined: wrap-around to 0 as above.

Decomposition:
- Package ucounter_pkg holds:
  - typedef enum logic [1:0] deb_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}
  - constant array SEG_LUT[0:9] of active-low 7-bit patterns
  - function bin_to_bcd (6-bit in, two 4-bit digits out)
- One sub-module, btn_debouncer (synchronizer + FSM + counter, outputs press_pulse); instantiated once.
- Count register and display logic live in ucounter_sync.

Test Plan (DEB_CYCLES=4, N=6):
- Reset: hold btn_reset=0 for 2 cycles -> count=0, tick=0, segA=segB=7'b1000000.
- Clean presses: 9 presses, each low 10 cycles / high 10 cycles -> count=9, exactly 9 tick pulses, segA=7'b0010000 ("9"), segB="0". Pressing again gives count=10, segA="0", segB=7'b1111001 ("1").
- Bounce rejection: btn_increment toggles low/high every cycle for 6 cycles, then stays high -> count unchanged, no tick.
- Held button: held low 100 cycles -> exactly one increment, tick high for one cycle at edge k+6.
- Wrap: drive count to 63, then press -> count=0, tick=1, displays "00". With UCOUNTER_SATURATE_EN defined: count stays 63, no tick.
- Reset mid-debounce: reset asserted in PRESS_WAIT -> count=0, no tick. Button held low through reset release -> one increment 6 cycles after release.
